seq_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier; next generation of the team's fixed 4x4 multiplier. Generalised to WIDTH-bit operands with a run-time signed/unsigned mode, a registered 2*WIDTH-bit product and a one-cycle done pulse alongside ready. Sits in the arithmetic path wherever a low-area, fixed-latency multiply is acceptable. It keeps the existing datapath/controller split.

---
 rtl/seq_mul_pkg.sv | 7 +
 rtl/seq_mul_ctrl.sv | 37 +++
 rtl/seq_mul_datapath.sv | 48 ++++
 rtl/seq_multiplier.sv | 24 ++
 tb/tb_seq_multiplier.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared FSM encoding and sizing helper for the sequential multiplier
package seq_mul_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/seq_mul_ctrl.sv
// seq_mul_ctrl: IDLE/CALC/FINISH sequencer with iteration counter
module seq_mul_ctrl
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic load,
  output logic step,
  output logic finish,
  output logic ready,
  output logic done
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= load ? '0 : step ? cnt + 1'b1 : cnt;
    end
  end
  // FINISH also accepts start, giving back-to-back operation
  always_comb begin
    ready = state != CALC;
    done = state == FINISH;
    step = state == CALC;
    load = ready && start;
    finish = step && cnt == CW'(WIDTH - 1);
    state_n = load ? CALC : finish ? FINISH : step ? CALC : IDLE;
  end
endmodule

// File: rtl/seq_mul_datapath.sv
// seq_mul_datapath: magnitude capture, shift-add accumulator and sign-corrected product register
module seq_mul_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic               mode_signed,
  input  logic [WIDTH-1:0]   in_1,
  input  logic [WIDTH-1:0]   in_2,
  output logic [2*WIDTH-1:0] out
);
  logic [WIDTH-1:0]   mcand, mplier, mag_1, mag_2, mplier_n;
  logic [WIDTH:0]     acc, sum, acc_n;
  logic [2*WIDTH-1:0] prod;
  logic               neg;
  // The final step's shifted product is written straight into out so it is valid in the done cycle
  always_comb begin
    mag_1 = mode_signed && in_1[WIDTH-1] ? -in_1 : in_1;
    mag_2 = mode_signed && in_2[WIDTH-1] ? -in_2 : in_2;
    sum = acc + (mplier[0] ? {1'b0, mcand} : '0);
    acc_n = {1'b0, sum[WIDTH:1]};
    mplier_n = {sum[0], mplier[WIDTH-1:1]};
    prod = {acc_n[WIDTH-1:0], mplier_n};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      neg <= 1'b0;
      out <= '0;
    end else begin
      if (load) begin
        mcand <= mag_1;
        mplier <= mag_2;
        acc <= '0;
        neg <= mode_signed && (in_1[WIDTH-1] ^ in_2[WIDTH-1]);
      end else if (step) begin
        acc <= acc_n;
        mplier <= mplier_n;
      end
      if (finish) out <= neg ? -prod : prod;
    end
  end
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: fixed-latency signed/unsigned shift-add multiplier (datapath + controller)
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode_signed,
  input  logic [WIDTH-1:0]   in_1,
  input  logic [WIDTH-1:0]   in_2,
  output logic [2*WIDTH-1:0] out,
  output logic               ready,
  output logic               done
);
  logic load, step, finish;
  seq_mul_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk(clk), .rst(rst), .start(start), .load(load), .step(step),
    .finish(finish), .ready(ready), .done(done)
  );
  seq_mul_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk(clk), .rst(rst), .load(load), .step(step), .finish(finish),
    .mode_signed(mode_signed), .in_1(in_1), .in_2(in_2), .out(out)
  );
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: scoreboard bench for WIDTH=4/8/16 multiplier instances
module tb_seq_multiplier;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, passes = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic rst8 = 1'b0, rsto = 1'b0;
  logic s4 = 0, m4 = 0, s8 = 0, m8 = 0, s16 = 0, m16 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic [7:0] out4;
  logic [15:0] out8;
  logic [31:0] out16;
  logic rdy4, dn4, rdy8, dn8, rdy16, dn16;
  logic [63:0] q4[$], q8[$], q16[$];
  int t4[$], t8[$], t16[$];
  logic pd4 = 0, pd8 = 0, pd16 = 0;
  logic [63:0] po4 = 0, po8 = 0, po16 = 0;
  logic ld8, ldx;
  seq_multiplier #(.WIDTH(4)) u4 (.clk(clk), .rst(rsto), .start(s4), .mode_signed(m4),
    .in_1(a4), .in_2(b4), .out(out4), .ready(rdy4), .done(dn4));
  seq_multiplier #(.WIDTH(8)) u8 (.clk(clk), .rst(rst8), .start(s8), .mode_signed(m8),
    .in_1(a8), .in_2(b8), .out(out8), .ready(rdy8), .done(dn8));
  seq_multiplier #(.WIDTH(16)) u16 (.clk(clk), .rst(rsto), .start(s16), .mode_signed(m16),
    .in_1(a16), .in_2(b16), .out(out16), .ready(rdy16), .done(dn16));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  function automatic logic [63:0] gold(input int w, input logic [31:0] a, input logic [31:0] b,
                                       input logic m);
    longint x, y;
    x = longint'(a);
    y = longint'(b);
    if (m && a[w-1]) x = x - (longint'(1) << w);
    if (m && b[w-1]) y = y - (longint'(1) << w);
    return 64'(x * y) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction
  function automatic logic rdy(input int w);
    return w == 4 ? rdy4 : w == 8 ? rdy8 : rdy16;
  endfunction
  task automatic set(input int w, input logic [31:0] a, input logic [31:0] b, input logic m,
                     input logic s);
    if (w == 4) begin a4 = a[3:0]; b4 = b[3:0]; m4 = m; s4 = s; end
    else if (w == 8) begin a8 = a[7:0]; b8 = b[7:0]; m8 = m; s8 = s; end
    else begin a16 = a[15:0]; b16 = b[15:0]; m16 = m; s16 = s; end
  endtask
  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b, input logic m,
                       input logic [63:0] e, input bit push, output logic ld);
    for (int i = 0; i < 200 && !rdy(w); i++) @(negedge clk);
    chk($sformatf("w%0d_ready_wait", w), 64'(rdy(w)), 64'd1);
    ld = w == 4 ? dn4 : w == 8 ? dn8 : dn16;
    set(w, a, b, m, 1'b1);
    @(posedge clk);
    #1;
    if (push) begin
      if (w == 4) begin q4.push_back(e); t4.push_back(cyc); end
      else if (w == 8) begin q8.push_back(e); t8.push_back(cyc); end
      else begin q16.push_back(e); t16.push_back(cyc); end
    end
    set(w, ~a, ~b, ~m, 1'b0);
    @(negedge clk);
  endtask
  task automatic mon(input int w, input logic d, input logic pd, input logic rs,
                     input logic [63:0] o, input logic [63:0] po);
    int n, t;
    logic [63:0] e;
    if (d) begin
      n = w == 4 ? q4.size() : w == 8 ? q8.size() : q16.size();
      chk($sformatf("w%0d_expected_done", w), 64'(n > 0), 64'd1);
      if (n > 0) begin
        if (w == 4) begin e = q4.pop_front(); t = t4.pop_front(); end
        else if (w == 8) begin e = q8.pop_front(); t = t8.pop_front(); end
        else begin e = q16.pop_front(); t = t16.pop_front(); end
        chk($sformatf("w%0d_product", w), o, e);
        chk($sformatf("w%0d_latency", w), 64'(cyc - t), 64'(w));
      end
      chk($sformatf("w%0d_done_single", w), 64'(pd), 64'd0);
    end else if (rs && o !== po) chk($sformatf("w%0d_out_hold", w), o, po);
  endtask
  always @(negedge clk) begin
    mon(4, dn4, pd4, rsto, 64'(out4), po4);
    mon(8, dn8, pd8, rst8, 64'(out8), po8);
    mon(16, dn16, pd16, rsto, 64'(out16), po16);
    pd4 <= dn4; pd8 <= dn8; pd16 <= dn16;
    po4 <= 64'(out4); po8 <= 64'(out8); po16 <= 64'(out16);
  end
  initial begin
    s8 = 1'b1;
    a8 = 8'd9;
    b8 = 8'd9;
    repeat (3) @(negedge clk);
    chk("reset_out", 64'(out8), 64'd0);
    chk("reset_ready", 64'(rdy8), 64'd1);
    chk("reset_done", 64'(dn8), 64'd0);
    s8 = 1'b0;
    #2 rst8 = 1'b1; rsto = 1'b1;
    @(negedge clk);
    chk("reset_start_ignored", 64'(rdy8), 64'd1);
    fork
      begin
        drive(8, 200, 255, 0, 64'hC738, 1, ld8);
        drive(8, 8'h80, 8'h80, 1, 64'h4000, 1, ld8);
        drive(8, 8'h80, 8'h7F, 1, 64'hC080, 1, ld8);
        drive(8, 8'hFF, 8'h01, 1, 64'hFFFF, 1, ld8);
        drive(8, 8'h00, 8'hFB, 1, 64'h0000, 1, ld8);
        drive(8, 8'hFF, 8'hFF, 0, 64'hFE01, 1, ld8);
        drive(8, 8'hFF, 8'hFF, 1, 64'h0001, 1, ld8);
        drive(8, 3, 4, 0, 64'd12, 1, ld8);
        repeat (2) @(negedge clk);
        set(8, 9, 9, 0, 1'b1);
        @(negedge clk);
        set(8, 9, 9, 0, 1'b0);
        drive(8, 10, 10, 0, 64'd100, 1, ld8);
        drive(8, 11, 11, 0, 64'd121, 1, ld8);
        chk("w8_back_to_back", 64'(ld8), 64'd1);
        drive(8, 5, 5, 0, 64'd25, 0, ld8);
        repeat (3) @(negedge clk);
        #2 rst8 = 1'b0;
        #1;
        chk("midop_reset_out", 64'(out8), 64'd0);
        chk("midop_reset_ready", 64'(rdy8), 64'd1);
        chk("midop_reset_done", 64'(dn8), 64'd0);
        @(negedge clk);
        #2 rst8 = 1'b1;
        repeat (12) @(negedge clk);
        drive(8, 7, 6, 0, 64'd42, 1, ld8);
        for (int a = 0; a < 256; a += 17)
          for (int b = 3; b < 256; b += 23)
            for (int m = 0; m < 2; m++)
              drive(8, a, b, m[0], gold(8, a, b, m[0]), 1, ld8);
      end
      begin
        drive(4, 8, 8, 1, 64'h40, 1, ldx);
        drive(16, 32'hFFFF, 32'hFFFF, 0, 64'hFFFE0001, 1, ldx);
        drive(16, 32'h8000, 32'h8000, 1, 64'h40000000, 1, ldx);
        drive(16, 32'hFFFF, 32'h0002, 1, 64'hFFFFFFFE, 1, ldx);
        for (int m = 0; m < 2; m++)
          for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
              drive(4, a, b, m[0], gold(4, a, b, m[0]), 1, ldx);
      end
    join
    for (int i = 0; i < 100 && (q4.size() + q8.size() + q16.size()) != 0; i++) @(negedge clk);
    chk("queues_drained", 64'(q4.size() + q8.size() + q16.size()), 64'd0);
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
